// File: rtl/token_buffer_arb_pkg.sv
// token_buf_pkg: shared constants and helpers for the arbitrated token buffer.
// Rev 1.0
`default_nettype none

package token_buf_pkg;

   localparam int ARB_RR     = 0;
   localparam int ARB_FIXED  = 1;

   localparam int DEF_DATA_W = 1024;
   localparam int DEF_DEPTH  = 256;

   // Width needed to hold a channel index; never narrower than one bit.
   function automatic int ch_idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage : token_buf_pkg

`default_nettype wire

// File: rtl/token_buffer_arb_rr_arbiter.sv
// rr_arbiter: one-hot single-winner arbiter, round-robin or fixed lowest-index priority.
// Rev 1.0
`default_nettype none

module rr_arbiter
   import token_buf_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int ARB_MODE = ARB_RR
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] req,
   input  logic              advance,
   output logic [NUM_CH-1:0] gnt
);

   localparam int IW = ch_idx_w(NUM_CH);

   logic [IW-1:0] ptr;
   logic [IW-1:0] win;
   logic          found;
   int            c;

   // Scan from the pointer (or from 0 in fixed mode), wrapping at NUM_CH.
   always_comb begin
      gnt   = '0;
      win   = '0;
      found = 1'b0;
      c     = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         c = (ARB_MODE == ARB_FIXED) ? i : (int'(ptr) + i) % NUM_CH;
         if (!found && req[c]) begin
            found  = 1'b1;
            gnt[c] = 1'b1;
            win    = IW'(c);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (advance && found) begin
         ptr <= (win == IW'(NUM_CH - 1)) ? '0 : win + 1'b1;
      end
   end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/token_buffer_arb.sv
// token_buffer_arb: NUM_CH req/gnt clients sharing one single-port DEPTH x DATA_W token array.
// Rev 1.0
`default_nettype none

module token_buffer_arb
   import token_buf_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int ARB_MODE = ARB_RR
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH-1:0]        in_req,
   input  logic [NUM_CH-1:0]        in_we,
   input  logic [NUM_CH*ADDR_W-1:0] in_addr,
   input  logic [NUM_CH*DATA_W-1:0] in_wdata,
   output logic [NUM_CH-1:0]        out_gnt,
   output logic [DATA_W-1:0]        out_rdata,
   output logic [NUM_CH-1:0]        out_rvalid,
   output logic                     out_err
);

   localparam int                CH_W    = ch_idx_w(NUM_CH);
   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

   logic              accept;
   logic [CH_W-1:0]   sel_ch;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   logic              a_valid;
   logic [CH_W-1:0]   a_ch;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata;
   logic              a_in_range;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_word;
   logic              rd_ok;

   rr_arbiter #(
      .NUM_CH   (NUM_CH),
      .ARB_MODE (ARB_MODE)
   ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (in_req),
      .advance (accept),
      .gnt     (out_gnt)
   );

   assign accept = |out_gnt;

   always_comb begin
      sel_ch    = '0;
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (out_gnt[i]) begin
            sel_ch    = CH_W'(i);
            sel_we    = in_we[i];
            sel_addr  = in_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = in_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // Stage A: only the valid bit needs reset; payload is qualified by it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_valid <= 1'b0;
      end else begin
         a_valid <= accept;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         a_ch    <= sel_ch;
         a_we    <= sel_we;
         a_addr  <= sel_addr;
         a_wdata <= sel_wdata;
      end
   end

   assign a_in_range = ({1'b0, a_addr} < DEPTH_L);

   // Stage B: single-port array, registered read, not reset.
   always_ff @(posedge clk) begin
      if (a_valid && a_in_range) begin
         if (a_we) begin
            mem[a_addr] <= a_wdata;
         end else begin
            rd_word <= mem[a_addr];
         end
      end
   end

   // Stage C: control flags reset asynchronously; data is zero-gated by rd_ok.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_rvalid <= '0;
         rd_ok      <= 1'b0;
         out_err    <= 1'b0;
      end else begin
         out_rvalid <= (a_valid && !a_we) ? (NUM_CH'(1) << a_ch) : '0;
         rd_ok      <= a_valid && !a_we && a_in_range;
         out_err    <= a_valid && !a_in_range;
      end
   end

   assign out_rdata = rd_ok ? rd_word : '0;

endmodule : token_buffer_arb

`default_nettype wire

// File: tb/tb_token_buffer_arb.sv
// tb_token_buffer_arb: directed checks of arbitration, latency, range errors and reset.
// Rev 1.0
`default_nettype none

module tb_token_buffer_arb;

   localparam int NCH = 4;
   localparam int DW  = 32;
   localparam int AW  = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic [NCH-1:0]    req  = '0, we  = '0;
   logic [NCH*AW-1:0] addr = '0;
   logic [NCH*DW-1:0] wdata = '0;
   logic [NCH-1:0]    gnt, rvalid;
   logic [DW-1:0]     rdata;
   logic              err;

   logic [NCH-1:0]    req1 = '0, we1 = '0;
   logic [NCH*AW-1:0] addr1 = '0;
   logic [NCH*DW-1:0] wdata1 = '0;
   logic [NCH-1:0]    gnt1, rvalid1;
   logic [DW-1:0]     rdata1;
   logic              err1;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   token_buffer_arb #(
      .NUM_CH(NCH), .DATA_W(DW), .DEPTH(200), .ADDR_W(AW), .ARB_MODE(0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_req(req), .in_we(we), .in_addr(addr),
      .in_wdata(wdata), .out_gnt(gnt), .out_rdata(rdata), .out_rvalid(rvalid),
      .out_err(err)
   );

   token_buffer_arb #(
      .NUM_CH(NCH), .DATA_W(DW), .DEPTH(256), .ADDR_W(AW), .ARB_MODE(1)
   ) dut_fix (
      .clk(clk), .rst_n(rst_n), .in_req(req1), .in_we(we1), .in_addr(addr1),
      .in_wdata(wdata1), .out_gnt(gnt1), .out_rdata(rdata1), .out_rvalid(rvalid1),
      .out_err(err1)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int c, input logic r, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      req[c]           = r;
      we[c]            = w;
      addr[c*AW +: AW] = a;
      wdata[c*DW +: DW] = d;
   endtask

   task automatic all_read(input logic [AW-1:0] a);
      for (int c = 0; c < NCH; c++) drive(c, 1'b1, 1'b0, a, '0);
   endtask

   task automatic idle();
      for (int c = 0; c < NCH; c++) drive(c, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      tick();
      tick();
      chk("rst_rvalid", 64'(rvalid), 64'h0);
      chk("rst_rdata", 64'(rdata), 64'h0);
      chk("rst_err", 64'(err), 64'h0);
      chk("rst_gnt_idle", 64'(gnt), 64'h0);
      rst_n = 1'b1;

      // Write ch0 addr 5, then read it from ch1.
      tick();
      drive(0, 1'b1, 1'b1, 8'd5, 32'hA5A5_A5A5);
      #1 chk("wr5_gnt", 64'(gnt), 64'b0001);
      tick();
      drive(0, 1'b0, 1'b0, '0, '0);
      drive(1, 1'b1, 1'b0, 8'd5, '0);
      #1 chk("rd5_gnt", 64'(gnt), 64'b0010);
      tick();
      idle();
      #1 chk("wr_no_rvalid", 64'(rvalid), 64'h0);
      chk("idle_gnt", 64'(gnt), 64'h0);
      tick();
      chk("rd5_rvalid", 64'(rvalid), 64'b0010);
      chk("rd5_rdata", 64'(rdata), 64'hA5A5_A5A5);
      chk("rd5_err", 64'(err), 64'h0);
      tick();
      chk("rd5_rvalid_drop", 64'(rvalid), 64'h0);
      chk("rd5_rdata_gate", 64'(rdata), 64'h0);

      // Back-to-back write then read of addr 9; pointer sits at 2.
      drive(2, 1'b1, 1'b1, 8'd9, 32'h1234_5678);
      #1 chk("wr9_gnt", 64'(gnt), 64'b0100);
      tick();
      drive(2, 1'b0, 1'b0, '0, '0);
      drive(3, 1'b1, 1'b0, 8'd9, '0);
      #1 chk("rd9_gnt", 64'(gnt), 64'b1000);
      tick();
      idle();
      tick();
      chk("rd9_rvalid", 64'(rvalid), 64'b1000);
      chk("rd9_rdata", 64'(rdata), 64'h1234_5678);

      // Out-of-range write and read at addr 210 (DEPTH 200).
      tick();
      drive(0, 1'b1, 1'b1, 8'd210, 32'hDEAD_BEEF);
      #1 chk("oor_wr_gnt", 64'(gnt), 64'b0001);
      tick();
      drive(0, 1'b0, 1'b0, '0, '0);
      drive(1, 1'b1, 1'b0, 8'd210, '0);
      #1 chk("oor_rd_gnt", 64'(gnt), 64'b0010);
      tick();
      idle();
      #1 chk("oor_wr_err", 64'(err), 64'h1);
      chk("oor_wr_rvalid", 64'(rvalid), 64'h0);
      tick();
      chk("oor_rd_err", 64'(err), 64'h1);
      chk("oor_rd_rvalid", 64'(rvalid), 64'b0010);
      chk("oor_rd_rdata", 64'(rdata), 64'h0);
      tick();
      chk("oor_err_clear", 64'(err), 64'h0);
      chk("addr10_untouched_rvalid", 64'(rvalid), 64'h0);

      // Continuous reads from all channels, then reset with reads in flight.
      all_read(8'd5);
      #1 chk("ip_gnt0", 64'(gnt), 64'b0100);
      tick();
      chk("ip_gnt1", 64'(gnt), 64'b1000);
      tick();
      chk("ip_gnt2", 64'(gnt), 64'b0001);
      chk("ip_rvalid", 64'(rvalid), 64'b0100);
      #1 rst_n = 1'b0;
      #1 chk("async_rst_rvalid", 64'(rvalid), 64'h0);
      chk("async_rst_rdata", 64'(rdata), 64'h0);
      tick();
      chk("in_rst_gnt_ptr0", 64'(gnt), 64'b0001);
      chk("in_rst_rvalid", 64'(rvalid), 64'h0);
      rst_n = 1'b1;

      // After release the pointer starts at ch0.
      #1 chk("rr_gnt0", 64'(gnt), 64'b0001);
      tick();
      chk("rr_gnt1", 64'(gnt), 64'b0010);
      chk("rr_no_stale", 64'(rvalid), 64'h0);
      tick();
      chk("rr_gnt2", 64'(gnt), 64'b0100);
      chk("rr_rv0", 64'(rvalid), 64'b0001);
      chk("rr_rd0", 64'(rdata), 64'hA5A5_A5A5);
      tick();
      chk("rr_gnt3", 64'(gnt), 64'b1000);
      chk("rr_rv1", 64'(rvalid), 64'b0010);
      tick();
      chk("rr_gnt4", 64'(gnt), 64'b0001);
      chk("rr_rv2", 64'(rvalid), 64'b0100);
      tick();
      chk("rr_rv3", 64'(rvalid), 64'b1000);
      idle();

      // Fixed priority: ch0 and ch2 both request; ch0 always wins.
      chk("fix_idle_gnt", 64'(gnt1), 64'h0);
      req1 = 4'b0101;
      we1  = 4'b0000;
      #1 chk("fix_gnt_a", 64'(gnt1), 64'b0001);
      tick();
      chk("fix_gnt_b", 64'(gnt1), 64'b0001);
      tick();
      chk("fix_gnt_c", 64'(gnt1), 64'b0001);
      chk("fix_rvalid", 64'(rvalid1), 64'b0001);
      req1 = 4'b0100;
      #1 chk("fix_gnt_ch2", 64'(gnt1), 64'b0100);
      tick();
      req1 = 4'b0000;
      tick();
      chk("fix_rvalid_ch2", 64'(rvalid1), 64'b0100);
      tick();
      chk("fix_rvalid_end", 64'(rvalid1), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_token_buffer_arb

`default_nettype wire

// File: doc/token_buffer_arb.md
# token_buffer_arb

Parametrised, arbitrated successor to the single-port token SRAM buffer. NUM_CH clients (DRAM loader, dispatcher, collector, gating, …) issue read/write requests with a req/gnt handshake, and an internal arbiter replaces the externally driven source select. The block returns read data with a per-channel one-hot valid. It sits between the MoE datapath clients and one DEPTH x DATA_W token array.

## Interface
Parameters:
- NUM_CH, 4: number of client channels (2..8).
- DATA_W, 1024: token word width.
- DEPTH, 256: number of words (any value ≥ 2).
- ADDR_W, $clog2(DEPTH): address width.
- ARB_MODE, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_req  in  NUM_CH  per-channel request; held with its fields until granted.
- in_we  in  NUM_CH  1 = write, 0 = read.
- in_addr  in  NUM_CH*ADDR_W  packed addresses; channel c occupies [c*ADDR_W +: ADDR_W].
- in_wdata  in  NUM_CH*DATA_W  packed write data.
- out_gnt  out  NUM_CH  one-hot, combinational; request accepted this cycle.
- out_rdata  out  DATA_W  shared read-data bus.
- out_rvalid  out  NUM_CH  one-hot; out_rdata belongs to this channel.
- out_err  out  1  one-cycle pulse; an accepted access had addr ≥ DEPTH.

## Operation
- Arbitration:
  - Each cycle at most one request is granted: out_gnt = arbiter(in_req, pointer).
  - out_gnt is 0 when in_req is 0.
  - A channel's request is accepted in the cycle its out_gnt is 1.
- ARB_MODE 0:
  - After a grant to channel g, the priority pointer moves to (g+1) mod NUM_CH.
  - No grant leaves the pointer unchanged.
  - Any requester waits at most NUM_CH-1 grants.
- ARB_MODE 1: the lowest-index requester wins; the pointer is unused.
- Stage A (register):
  - On acceptance, latch valid, channel index, we, addr and wdata.
  - No acceptance latches valid = 0.
- Stage B (array access):
  - A latched write performs array[addr] <= wdata.
  - A latched read drives array[addr] into the output register.
- Stage C (output register):
  - out_rvalid[ch] = 1 and out_rdata = read word for exactly one cycle.
  - Otherwise out_rvalid = 0 and out_rdata = 0; out_rdata is zero-gated.
- Writes produce no out_rvalid.
- Out of range (addr ≥ DEPTH):
  - Writes are dropped.
  - Reads return 0 with the normal out_rvalid.
  - out_err pulses in the Stage C cycle.
- Ordering: a read accepted in any cycle after a write's acceptance returns the new data. There are no hazards, because the array is accessed in acceptance order.
- Array contents are not reset.

## Timing
- Grant: combinational from in_req in the same cycle. Clients sample out_gnt at the clock edge and may drop or change in_req in the next cycle.
- Read accepted in cycle T: out_rvalid and out_rdata are valid in cycle T+2.
- Write accepted in cycle T: array updated at the end of cycle T+1.
- Throughput: one access per cycle, sustained, across any channel mix.
- Reset, asynchronous assertion clears:
  - Stage A/B/C valids, out_rvalid, out_rdata, out_err.
  - The RR pointer, to channel 0.
  - In-flight accesses are discarded; a pending write may or may not land and is unspecified.
- First grant after rst_n deasserts: possible in the first cycle with in_req ≠ 0.
- Simultaneous requests with pointer p: grant goes to the first requester at or after p, wrapping NUM_CH-1 → 0.

## Structure
- Shared package token_buf_pkg holds:
  - ARB_RR = 0, ARB_FIXED = 1.
  - Default DATA_W and DEPTH constants.
  - The channel-index width function, clog2-based with a minimum of 1.
- Sub-module rr_arbiter (params NUM_CH, ARB_MODE):
  - Inputs: req, advance.
  - Output: one-hot gnt.
  - Holds the pointer internally.
- The array is inferred inside the top level or via the existing SRAM wrapper style. It has one port, with a synchronous registered read.

## Test plan
- Reset, then write ch0 addr 5 = 0xA5.., then read ch1 addr 5 at T → out_rvalid = 4'b0010 and out_rdata = 0xA5.. at T+2; out_gnt asserted at T.
- All four channels request reads continuously from reset → grants 0,1,2,3,0,… one per cycle; out_rvalid follows the same sequence two cycles later.
- ARB_MODE = 1, ch0 and ch2 requesting continuously → ch0 always granted; ch2 is never granted until ch0 drops.
- Back-to-back: write addr 9 at T, read addr 9 at T+1 → the read returns the new data at T+3.
- DEPTH = 200: write addr 210, then read addr 210 → write dropped; read gives out_rdata = 0 with rvalid; out_err pulses for both accesses.
- Assert rst_n low while reads are in flight → out_rvalid = 0 immediately; after release, the first grant goes to ch0 when all channels request.
